// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: fetches instructions over a req/valid
// handshake, holds them in an instruction register, sequences the datapath
// control strobes per instruction class and owns the PC (including beq/j).
// Every output is a flop; the next-state process computes the value each
// output takes in the state being entered.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  output logic [31:0] I,
  output logic [2:0]  opcode,
  output logic        RegW,
  output logic        Regdst,
  output logic        ALUSrc,
  output logic        MemR,
  output logic        MemW,
  output logic        MemtoReg,
  output logic [31:0] pc,
  output logic        instr_done,
  output logic        halted,
  output logic        fetch_err,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [31:0] TIMEOUT = FETCH_TIMEOUT[31:0];

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [2:0]  opcode_reg, opcode_next;
  logic        regdst_reg, regdst_next;
  logic        alusrc_reg, alusrc_next;
  logic        memtoreg_reg, memtoreg_next;
  logic        regw_reg, regw_next;
  logic        memw_reg, memw_next;
  logic        memr_reg, memr_next;
  logic        done_reg, done_next;
  logic        req_reg, req_next;
  logic        halted_reg, halted_next;
  logic        fetch_err_reg, fetch_err_next;
  logic        illegal_reg, illegal_next;

  logic [5:0]  op_field;
  logic [5:0]  fn_field;
  logic [2:0]  r_alu;
  logic        r_ok;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;
  logic [31:0] br_off;

  // Classify the held instruction; the IR is stable from DECODE through WB
  always_comb begin
    op_field = ir_reg[31:26];
    fn_field = ir_reg[5:0];
    r_alu    = ALU_ADD;
    r_ok     = 1'b1;
    case (fn_field)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
    is_r     = (op_field == OP_RTYPE) && r_ok;
    is_addi  = (op_field == OP_ADDI);
    is_lw    = (op_field == OP_LW);
    is_sw    = (op_field == OP_SW);
    is_beq   = (op_field == OP_BEQ);
    is_j     = (op_field == OP_J);
    is_legal = is_r || is_addi || is_lw || is_sw || is_beq || is_j;
    br_off   = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
  end

  // Next state and next value of every registered output
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    cnt_next       = cnt_reg;
    opcode_next    = opcode_reg;
    regdst_next    = regdst_reg;
    alusrc_next    = alusrc_reg;
    memtoreg_next  = memtoreg_reg;
    regw_next      = 1'b0;
    memw_next      = 1'b0;
    memr_next      = 1'b0;
    done_next      = 1'b0;
    fetch_err_next = fetch_err_reg;
    illegal_next   = illegal_reg;

    case (state_reg)
      S_FETCH: begin
        if (imem_valid) begin
          ir_next    = imem_rdata;
          pc_next    = pc_reg + 32'd4;
          cnt_next   = '0;
          state_next = S_DECODE;
        end else begin
          cnt_next = cnt_reg + 32'd1;
          if ((TIMEOUT != 32'd0) && (cnt_next == TIMEOUT)) begin
            fetch_err_next = 1'b1;
            state_next     = S_HALT;
          end
        end
      end
      S_DECODE: begin
        if (is_j) begin
          // pc already holds the incremented address of the jump
          pc_next    = {pc_reg[31:28], ir_reg[25:0], 2'b00};
          done_next  = 1'b1;
          state_next = S_FETCH;
        end else if (!is_legal) begin
          illegal_next = 1'b1;
          state_next   = S_HALT;
        end else begin
          state_next = S_EXEC;
          if (is_r) begin
            opcode_next   = r_alu;
            alusrc_next   = 1'b1;
            regdst_next   = 1'b0;
            memtoreg_next = 1'b1;
          end else if (is_addi) begin
            opcode_next   = ALU_ADD;
            alusrc_next   = 1'b0;
            regdst_next   = 1'b1;
            memtoreg_next = 1'b1;
          end else if (is_lw || is_sw) begin
            opcode_next = ALU_ADD;
            alusrc_next = 1'b0;
          end
        end
      end
      S_EXEC: begin
        if (is_r || is_addi) begin
          regw_next  = 1'b1;
          state_next = S_WB;
        end else if (is_lw) begin
          memr_next     = 1'b1;
          regdst_next   = 1'b1;
          memtoreg_next = 1'b0;
          state_next    = S_MEM;
        end else if (is_sw) begin
          memw_next  = 1'b1;
          state_next = S_MEM;
        end else begin
          // beq: offset is relative to the already incremented pc
          if (reg1 == reg2) begin
            pc_next = pc_reg + br_off;
          end
          done_next  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          memr_next  = 1'b1;
          regw_next  = 1'b1;
          state_next = S_WB;
        end else begin
          done_next  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        done_next  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    req_next    = (state_next == S_FETCH);
    halted_next = (state_next == S_HALT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      cnt_reg       <= '0;
      opcode_reg    <= ALU_ADD;
      regdst_reg    <= 1'b0;
      alusrc_reg    <= 1'b1;
      memtoreg_reg  <= 1'b1;
      regw_reg      <= 1'b0;
      memw_reg      <= 1'b0;
      memr_reg      <= 1'b0;
      done_reg      <= 1'b0;
      req_reg       <= 1'b1;
      halted_reg    <= 1'b0;
      fetch_err_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      cnt_reg       <= cnt_next;
      opcode_reg    <= opcode_next;
      regdst_reg    <= regdst_next;
      alusrc_reg    <= alusrc_next;
      memtoreg_reg  <= memtoreg_next;
      regw_reg      <= regw_next;
      memw_reg      <= memw_next;
      memr_reg      <= memr_next;
      done_reg      <= done_next;
      req_reg       <= req_next;
      halted_reg    <= halted_next;
      fetch_err_reg <= fetch_err_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign imem_req   = req_reg;
  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign I          = ir_reg;
  assign opcode     = opcode_reg;
  assign RegW       = regw_reg;
  assign Regdst     = regdst_reg;
  assign ALUSrc     = alusrc_reg;
  assign MemR       = memr_reg;
  assign MemW       = memw_reg;
  assign MemtoReg   = memtoreg_reg;
  assign instr_done = done_reg;
  assign halted     = halted_reg;
  assign fetch_err  = fetch_err_reg;
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases plus random
// instruction streams, checked against a per-instruction reference model
// (class, latency, strobe counts, control selects, next PC).
module tb_mips_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h2000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] reg1, reg2;
  logic [31:0] I;
  logic [2:0]  opcode;
  logic        RegW, Regdst, ALUSrc, MemR, MemW, MemtoReg;
  logic [31:0] pc;
  logic        instr_done, halted, fetch_err, illegal;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_pc;

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

  mips_multicycle_ctrl #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .reg1(reg1), .reg2(reg2), .I(I), .opcode(opcode),
    .RegW(RegW), .Regdst(Regdst), .ALUSrc(ALUSrc), .MemR(MemR), .MemW(MemW), .MemtoReg(MemtoReg),
    .pc(pc), .instr_done(instr_done), .halted(halted), .fetch_err(fetch_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: instruction class and ALU operation from the ISA table
  function automatic kind_e classify(input logic [31:0] w, output logic [2:0] alu);
    kind_e k;
    alu = 3'b000;
    k   = K_ILL;
    case (w[31:26])
      6'h00: begin
        k = K_R;
        case (w[5:0])
          6'h20: alu = 3'b000;
          6'h22: alu = 3'b001;
          6'h24: alu = 3'b010;
          6'h25: alu = 3'b011;
          6'h2A: alu = 3'b100;
          default: k = K_ILL;
        endcase
      end
      6'h08: k = K_ADDI;
      6'h23: k = K_LW;
      6'h2B: k = K_SW;
      6'h04: k = K_BEQ;
      6'h02: k = K_J;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic int latency_of(input kind_e k);
    case (k)
      K_J, K_ILL:        return 2;
      K_BEQ:             return 3;
      K_LW:              return 5;
      default:           return 4;
    endcase
  endfunction

  function automatic logic [31:0] gen_word(input kind_e k);
    logic [31:0] w;
    logic [15:0] imm;
    w = $urandom;
    case (k)
      K_R: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 4))
          0: w[5:0] = 6'h20;
          1: w[5:0] = 6'h22;
          2: w[5:0] = 6'h24;
          3: w[5:0] = 6'h25;
          default: w[5:0] = 6'h2A;
        endcase
      end
      K_ADDI: w[31:26] = 6'h08;
      K_LW:   w[31:26] = 6'h23;
      K_SW:   w[31:26] = 6'h2B;
      K_BEQ: begin
        w[31:26] = 6'h04;
        imm = 16'($urandom_range(0, 64)) - 16'd32;
        w[15:0] = imm;
      end
      K_J:    w[31:26] = 6'h02;
      default: begin
        case ($urandom_range(0, 3))
          0: w[31:26] = 6'h3F;
          1: w[31:26] = 6'h01;
          2: w[31:26] = 6'h10;
          default: begin
            w[31:26] = 6'h00;
            w[5:0]   = 6'h21;
          end
        endcase
      end
    endcase
    return w;
  endfunction

  // Execute one instruction end to end and compare against the model
  task automatic run_instr(input logic [31:0] w, input int stall,
                           input logic [31:0] r1, input logic [31:0] r2);
    kind_e       k;
    logic [2:0]  alu;
    logic [31:0] inc_pc, next_pc, sext;
    int          lat, n_regw, n_memw, n_memr, n_both;
    bit          seen;
    k = classify(w, alu);
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("imem_addr", imem_addr, model_pc);
    imem_valid = 1'b0;
    for (int s = 0; s < stall; s++) tick();
    chk("req_after_stall", 32'(imem_req), 32'd1);
    imem_rdata = w;
    imem_valid = 1'b1;
    reg1 = r1;
    reg2 = r2;
    tick();
    lat = 1;
    inc_pc = model_pc + 32'd4;
    chk("ir_load", I, w);
    chk("pc_inc", pc, inc_pc);
    sext = {{14{w[15]}}, w[15:0], 2'b00};
    case (k)
      K_J:     next_pc = {inc_pc[31:28], w[25:0], 2'b00};
      K_BEQ:   next_pc = (r1 == r2) ? inc_pc + sext : inc_pc;
      default: next_pc = inc_pc;
    endcase
    n_regw = 0; n_memw = 0; n_memr = 0; n_both = 0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (RegW) begin
        n_regw++;
        case (k)
          K_R:    chk("wb_ctrl", {27'd0, opcode, ALUSrc, Regdst, MemtoReg}, {27'd0, alu, 3'b101});
          K_ADDI: chk("wb_ctrl", {27'd0, opcode, ALUSrc, Regdst, MemtoReg}, {27'd0, 3'b000, 3'b011});
          K_LW:   chk("wb_ctrl", {27'd0, opcode, ALUSrc, Regdst, MemtoReg, MemR}, {27'd0, 3'b000, 4'b0101});
          default: ;
        endcase
      end
      if (MemW) begin
        n_memw++;
        chk("mem_ctrl", {28'd0, opcode, ALUSrc}, 32'd0);
      end
      if (MemR) n_memr++;
      if (RegW && MemW) n_both++;
      if (instr_done || halted) begin
        seen = 1'b1;
      end else begin
        // imem_valid noise outside FETCH must be ignored
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        tick();
        lat++;
      end
    end
    imem_valid = 1'b0;
    chk("retire_seen", 32'(seen), 32'd1);
    chk("latency", lat, latency_of(k));
    chk("regw_pulses", n_regw, (k == K_R || k == K_ADDI || k == K_LW) ? 1 : 0);
    chk("memw_pulses", n_memw, (k == K_SW) ? 1 : 0);
    chk("memr_cycles", n_memr, (k == K_LW) ? 2 : 0);
    chk("regw_memw_both", n_both, 0);
    chk("illegal_flag", 32'(illegal), (k == K_ILL) ? 32'd1 : 32'd0);
    chk("halted_flag", 32'(halted), (k == K_ILL) ? 32'd1 : 32'd0);
    if (k != K_ILL) begin
      chk("next_pc", imem_addr, next_pc);
      chk("req_next", 32'(imem_req), 32'd1);
      model_pc = next_pc;
    end else begin
      chk("req_halt", 32'(imem_req), 32'd0);
    end
    $display("instr pc=%h word=%h kind=%0d lat=%0d next=%h", inc_pc - 32'd4, w, int'(k), lat, imem_addr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_valid = 1'b0;
    tick();
    reset = 1'b0;
    model_pc = RST_PC;
  endtask

  task automatic check_reset_state();
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", I, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_sel", {26'd0, opcode, Regdst, ALUSrc, MemtoReg}, {26'd0, 3'b000, 3'b011});
    chk("rst_strobes", {28'd0, RegW, MemR, MemW, instr_done}, 32'd0);
    chk("rst_flags", {29'd0, halted, fetch_err, illegal}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc, hold_ir, w, r1, r2;
    kind_e k;
    reset = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    reg1 = '0;
    reg2 = '0;
    tick();
    tick();
    do_reset();
    check_reset_state();

    // Directed: add, lw, sw
    run_instr(32'h0022_1820, 0, 32'd1, 32'd2);
    chk("add_pc", pc, RST_PC + 32'd4);
    run_instr(32'h8C25_0008, 1, 32'd3, 32'd4);
    run_instr(32'hAC25_0008, 2, 32'd3, 32'd4);

    // Directed: jump to pc 0x2000_0010 then beq taken / not taken
    run_instr(32'h0800_0004, 0, 32'd0, 32'd0);
    chk("j_to_10", imem_addr, 32'h2000_0010);
    run_instr(32'h1022_FFFE, 0, 32'd7, 32'd7);
    chk("beq_taken", imem_addr, 32'h2000_000C);
    run_instr(32'h0022_1820, 1, 32'd1, 32'd2);
    run_instr(32'h1022_FFFE, 0, 32'd7, 32'd8);
    chk("beq_not_taken", imem_addr, 32'h2000_0014);

    // Random legal instruction stream
    for (int n = 0; n < 60; n++) begin
      k = kind_e'($urandom_range(0, 5));
      w = gen_word(k);
      r1 = $urandom_range(0, 3);
      r2 = ($urandom_range(0, 1) == 1) ? r1 : 32'($urandom_range(0, 3));
      run_instr(w, $urandom_range(0, 3), r1, r2);
    end

    // Illegal word halts; fetch traffic then ignored
    run_instr(32'hFC00_0000, 1, 32'd0, 32'd0);
    hold_pc = pc;
    hold_ir = I;
    for (int c = 0; c < 5; c++) begin
      imem_valid = 1'b1;
      imem_rdata = 32'h0022_1820;
      tick();
    end
    imem_valid = 1'b0;
    chk("halt_hold", {29'd0, halted, illegal, imem_req}, 32'd6);
    chk("halt_pc", pc, hold_pc);
    chk("halt_ir", I, hold_ir);
    do_reset();
    check_reset_state();

    // Random illegal word from a random pc
    run_instr(gen_word(K_J), 0, 32'd0, 32'd0);
    run_instr(gen_word(K_ILL), 0, 32'd0, 32'd0);
    do_reset();

    // Fetch timeout
    for (int c = 0; c < TMO - 1; c++) tick();
    chk("tmo_early", {30'd0, fetch_err, halted}, 32'd0);
    tick();
    chk("tmo_fire", {29'd0, fetch_err, halted, imem_req}, 32'd6);
    do_reset();
    check_reset_state();

    // Reset during lw MEM cycle
    imem_rdata = 32'h8C25_0008;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    tick();
    chk("lw_mem_memr", 32'(MemR), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", {30'd0, imem_req, MemR}, 32'd2);
    chk("mid_rst_pc", pc, RST_PC);
    for (int c = 0; c < 4; c++) begin
      chk("mid_rst_regw", 32'(RegW), 32'd0);
      tick();
    end
    do_reset();

    // Jump keeps the upper pc nibble
    run_instr(32'h0800_0040, 0, 32'd0, 32'd0);
    chk("j_hi_nibble", imem_addr, 32'h2000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control unit: the driving end of the single-cycle datapath's control/instruction interface.
- Fetches instructions from an instruction memory over a req/valid handshake and holds each in an instruction register presented on I.
- Sequences the datapath control strobes (RegW, Regdst, ALUSrc, MemR, MemW, MemtoReg, opcode) per instruction class.
- Owns the PC, and resolves beq/j using the datapath's reg1/reg2 outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, max cycles waiting for imem_valid in FETCH before fetch_err; 0 disables the timeout

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, level, held until imem_valid
imem_addr  output  32  fetch address (= pc)
imem_rdata  input  32  instruction word, sampled when imem_valid=1 in FETCH
imem_valid  input  1  instruction data valid
reg1  input  32  datapath register read port 1 (rs)
reg2  input  32  datapath register read port 2 (rt)
I  output  32  instruction register to datapath
opcode  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt
RegW  output  1  register-file write strobe
Regdst  output  1  0 = rd (I[15:11]), 1 = rt (I[20:16])
ALUSrc  output  1  0 = sign-extended immediate, 1 = reg2
MemR  output  1  data SRAM read enable
MemW  output  1  data SRAM write strobe
MemtoReg  output  1  0 = SRAM data, 1 = ALU result written back
pc  output  32  current PC
instr_done  output  1  one-cycle pulse on instruction retirement
halted  output  1  1 in HALT state
fetch_err  output  1  sticky flag: fetch timeout
illegal  output  1  sticky flag: unsupported opcode/funct

Behaviour:
Reset and register rules
- Reset (sync, any state, overrides imem_valid that cycle) -> state FETCH, pc=RESET_PC, I=0, all strobes/flags/instr_done=0, opcode=000, Regdst=0, ALUSrc=1, MemtoReg=1, timeout counter=0.
- All outputs are registered. imem_req is asserted only in FETCH.

States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1.
  - On imem_valid: I<=imem_rdata, pc<=pc+4 (mod 2^32), counter cleared, go to DECODE.
  - Otherwise counter increments; on reaching FETCH_TIMEOUT (nonzero): fetch_err<=1, go to HALT.
- DECODE: classify I[31:26] and funct I[5:0].
  - R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - j: pc<={pc[31:28], I[25:0], 2'b00}, instr_done, go to FETCH.
  - Any other op/funct: illegal<=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: drive opcode and mux selects, held unchanged through WB.
  - R-type: ALUSrc=1, Regdst=0, MemtoReg=1; go to WB.
  - addi: ALUSrc=0, Regdst=1, MemtoReg=1, opcode=add; go to WB.
  - lw/sw: ALUSrc=0, opcode=add; go to MEM.
  - beq: if reg1==reg2, pc<=pc+(sext(I[15:0])<<2) (pc is already +4). instr_done, go to FETCH.
- MEM:
  - lw: MemR=1 (held through WB), Regdst=1, MemtoReg=0; go to WB.
  - sw: MemW=1 for exactly this cycle, instr_done, go to FETCH.
- WB: RegW=1 for exactly this cycle, instr_done, go to FETCH. RegW and MemR are cleared on exit.
- HALT: absorbing until reset; all strobes 0, imem_req=0.

Latency and invariants
- Latency in cycles, excluding fetch wait: j=2, beq=3, sw=4, R-type/addi=4, lw=5.
- RegW and MemW are never both 1.
- Neither RegW nor MemW is asserted outside WB/MEM.
- imem_valid outside FETCH is ignored.

Test Plan:
- Reset then imem returns add $3,$1,$2 (0x00221820) with 0-cycle stall -> imem_req, DECODE, EXEC (opcode=000, ALUSrc=1, Regdst=0), WB RegW=1 for 1 cycle; pc=4; instr_done at cycle 4.
- lw $5,8($1) (0x8C250008) -> ALUSrc=0, opcode=000; MEM MemR=1; WB RegW=1, Regdst=1, MemtoReg=0; sw $5,8($1) (0xAC250008) -> MemW=1 exactly one cycle, RegW never set.
- beq at pc=0x10, imm=0xFFFE: reg1=reg2=7 -> next imem_addr=0x0C; with reg1=7, reg2=8 -> next imem_addr=0x14.
- j 0x0000040 at pc=0x2000_0000 -> next imem_addr=0x2000_0100; RegW/MemW stay 0.
- Illegal word 0xFC000000 -> illegal=1, halted=1, imem_req=0 thereafter; imem_valid ignored until reset clears all flags.
- imem_valid held low 16 cycles -> fetch_err=1, HALT. Separately, reset asserted during a lw MEM cycle -> next cycle FETCH, pc=RESET_PC, MemR=0, RegW never pulses.
